// File: rtl/lcd1602_bus_decoder.sv
// -----------------------------------------------------------------------------
// lcd1602_bus_decoder
//
// Receiver for an HD44780-style 8-bit LCD bus (rs/rw/e/data). Each falling
// edge of E is decoded as either a command or a character write. The decoder
// keeps a 2x16 shadow DDRAM that mirrors what the panel would show.
//
// Ports
//   clk, rst      : single clock domain. rst is synchronous and active-high.
//   lcd_rs_i      : register select (0 = command, 1 = data).
//   lcd_rw_i      : 0 = write. 1 = read, which is unsupported and flagged.
//   lcd_e_i       : enable. A transaction commits on its falling edge.
//   lcd_data_i    : bus data byte.
//   rd_addr_i     : shadow read address {row, col[3:0]}.
//   rd_char_o     : shadow byte at rd_addr_i, with 1-cycle latency.
//   cursor_o      : current write address {row, col}.
//   display_on_o  : D bit from the last Display Control command.
//   busy_o        : high while the Clear Display sweep runs.
//   char_wr_o     : one-cycle pulse per committed character write.
//   cmd_o         : last committed command byte.
//   cmd_vld_o     : one-cycle pulse per committed command.
//   err_o         : sticky error flag. It is set by an rw=1 strobe, a strobe
//                   while busy, or a bad DDRAM address.
// -----------------------------------------------------------------------------
module lcd1602_bus_decoder #(
  parameter int SYNC_INPUTS  = 1,
  parameter int CLEAR_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_rs_i,
  input  logic       lcd_rw_i,
  input  logic       lcd_e_i,
  input  logic [7:0] lcd_data_i,
  input  logic [4:0] rd_addr_i,
  output logic [7:0] rd_char_o,
  output logic [4:0] cursor_o,
  output logic       display_on_o,
  output logic       busy_o,
  output logic       char_wr_o,
  output logic [7:0] cmd_o,
  output logic       cmd_vld_o,
  output logic       err_o
);

  localparam logic [7:0] SPACE    = 8'h20;
  localparam logic [4:0] CLR_LAST = 5'(CLEAR_CYCLES - 1);

  typedef enum logic [0:0] {IDLE, CLEAR} state_t;

  state_t     state, state_nxt;
  logic [4:0] clr_cnt;
  logic       inc;
  logic [7:0] shadow [32];

  // A DDRAM address is decodable only in row 0 (0x00-0x0F) or row 1 (0x40-0x4F).
  function automatic logic addr_ok(input logic [6:0] a);
    return (a[6:4] == 3'b000) || (a[6:4] == 3'b100);
  endfunction

  // {row, col} is laid out so that a plain 5-bit add or subtract gives the
  // wrap sequence row0 col15 -> row1 col0 -> ... -> row1 col15 -> row0 col0.
  function automatic logic [4:0] step_cursor(input logic [4:0] c, input logic up);
    return up ? c + 5'd1 : c - 5'd1;
  endfunction

  // ---- stage p0/p1: input synchroniser ----
  logic       e_s, rs_s, rw_s;
  logic [7:0] data_s;

  generate
    if (SYNC_INPUTS != 0) begin : g_sync
      logic       e_p0, e_p1;
      logic       rs_p0, rs_p1, rw_p0, rw_p1;
      logic [7:0] data_p0, data_p1;

      always_ff @(posedge clk) begin
        if (rst) begin
          e_p0 <= 1'b0;
          e_p1 <= 1'b0;
        end else begin
          e_p0 <= lcd_e_i;
          e_p1 <= e_p0;
        end
      end

      always_ff @(posedge clk) begin
        rs_p0   <= lcd_rs_i;
        rs_p1   <= rs_p0;
        rw_p0   <= lcd_rw_i;
        rw_p1   <= rw_p0;
        data_p0 <= lcd_data_i;
        data_p1 <= data_p0;
      end

      assign e_s    = e_p1;
      assign rs_s   = rs_p1;
      assign rw_s   = rw_p1;
      assign data_s = data_p1;
    end else begin : g_nosync
      assign e_s    = lcd_e_i;
      assign rs_s   = lcd_rs_i;
      assign rw_s   = lcd_rw_i;
      assign data_s = lcd_data_i;
    end
  endgenerate

  // ---- stage p2: edge detect ----
  // rs/rw/data come from the same stage as e_s. The bus holds them stable
  // around the falling edge of E, so no further delay is needed.
  logic e_p2;
  logic fe;

  always_ff @(posedge clk) begin
    if (rst) e_p2 <= 1'b0;
    else     e_p2 <= e_s;
  end

  assign fe = e_p2 & ~e_s;

  // ---- decode: next state and commit strobes ----
  logic       cmd_commit, chr_commit, err_set;
  logic [4:0] cur_nxt;
  logic       inc_nxt, disp_nxt;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;

  always_comb begin
    state_nxt  = state;
    cmd_commit = 1'b0;
    chr_commit = 1'b0;
    err_set    = 1'b0;
    cur_nxt    = cursor_o;
    inc_nxt    = inc;
    disp_nxt   = display_on_o;
    wr_en      = 1'b0;
    wr_addr    = cursor_o;
    wr_data    = data_s;

    case (state)
      IDLE: begin
        if (fe) begin
          if (rw_s) begin
            err_set = 1'b1;
          end else if (rs_s) begin
            chr_commit = 1'b1;
            wr_en      = 1'b1;
            cur_nxt    = step_cursor(cursor_o, inc);
          end else if (data_s != 8'h00) begin
            cmd_commit = 1'b1;
            casez (data_s)
              8'b1???????: begin
                if (addr_ok(data_s[6:0])) cur_nxt = {data_s[6], data_s[3:0]};
                else                      err_set = 1'b1;
              end
              8'b001?????, 8'b0001????: begin
                // Function set and shift commands are only recorded in cmd_o.
              end
              8'b00001???: disp_nxt  = data_s[2];
              8'b000001??: inc_nxt   = data_s[1];
              8'b0000001?: cur_nxt   = 5'd0;
              default:     state_nxt = CLEAR;   // only 8'b00000001 is left here
            endcase
          end
        end
      end

      CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = clr_cnt;
        wr_data = SPACE;
        if (fe) err_set = 1'b1;
        if (clr_cnt == CLR_LAST) begin
          state_nxt = IDLE;
          cur_nxt   = 5'd0;
          inc_nxt   = 1'b1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // ---- stage commit: control registers and pulse outputs ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      clr_cnt      <= 5'd0;
      cursor_o     <= 5'd0;
      inc          <= 1'b1;
      display_on_o <= 1'b0;
      err_o        <= 1'b0;
      cmd_o        <= 8'h00;
      cmd_vld_o    <= 1'b0;
      char_wr_o    <= 1'b0;
    end else begin
      state        <= state_nxt;
      clr_cnt      <= (state == CLEAR) ? clr_cnt + 5'd1 : 5'd0;
      cursor_o     <= cur_nxt;
      inc          <= inc_nxt;
      display_on_o <= disp_nxt;
      err_o        <= err_o | err_set;
      cmd_vld_o    <= cmd_commit;
      char_wr_o    <= chr_commit;
      if (cmd_commit) cmd_o <= data_s;
    end
  end

  assign busy_o = (state == CLEAR);

  // Shadow RAM contents survive reset. A reset during the sweep blocks the
  // write of the entry that the sweep would have cleared in that cycle.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) shadow[wr_addr] <= wr_data;
  end

  // The read is registered. On a same-address collision with a write it
  // returns the old value.
  always_ff @(posedge clk) begin
    if (rst) rd_char_o <= 8'h00;
    else     rd_char_o <= shadow[rd_addr_i];
  end

endmodule
